// File: rtl/baud_tick_gen.sv
// UART baud-rate generator: dual-modulus oversample period counter with a
// fractional accumulator, an oversample index and glitch-free divisor loading.
module baud_tick_gen #(
  parameter int BITS        = 11,
  parameter int FRAC_BITS   = 4,
  parameter int OS_BITS     = 4,
  parameter int DEFAULT_INT = 326
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BITS-1:0]      div_int,
  input  logic [FRAC_BITS-1:0] div_frac,
  input  logic                 div_load,
  input  logic                 restart,
  output logic                 os_tick,
  output logic                 mid_tick,
  output logic                 bit_tick,
  output logic                 load_pending
);

  localparam logic [BITS-1:0]    DEF_INT   = BITS'(DEFAULT_INT);
  localparam logic [BITS-1:0]    DEF_LIMIT = BITS'(DEFAULT_INT - 1);
  localparam logic [BITS-1:0]    ONE       = BITS'(1);
  localparam logic [OS_BITS-1:0] OS_ONE    = OS_BITS'(1);
  localparam logic [OS_BITS-1:0] MID_IDX   = OS_BITS'((2 ** (OS_BITS - 1)) - 1);
  localparam logic [OS_BITS-1:0] BIT_IDX   = {OS_BITS{1'b1}};

  logic [BITS-1:0]      cnt;
  logic [BITS-1:0]      limit;
  logic [OS_BITS-1:0]   os_cnt;
  logic [FRAC_BITS-1:0] acc;
  logic [BITS-1:0]      div_int_q;
  logic [FRAC_BITS-1:0] div_frac_q;
  logic [BITS-1:0]      pend_int;
  logic [FRAC_BITS-1:0] pend_frac;
  logic                 pending;

  logic                 wrap;
  logic [BITS-1:0]      int_eff;
  logic [FRAC_BITS-1:0] frac_eff;
  logic [FRAC_BITS:0]   acc_sum;
  logic                 frac_used;
  logic                 carry;
  logic [BITS-1:0]      base_limit;

  // Divisor in force for any update this cycle: a same-cycle load beats the
  // pending value, which beats the active one.
  always_comb begin
    int_eff  = div_int_q;
    frac_eff = div_frac_q;
    if (div_load) begin
      int_eff  = div_int;
      frac_eff = div_frac;
    end else if (pending) begin
      int_eff  = pend_int;
      frac_eff = pend_frac;
    end
  end

  // Fraction only applies where the extra clock cannot overflow the counter
  // and the divisor is large enough to have a real period.
  always_comb begin
    wrap       = enable & ~restart & (cnt == limit);
    frac_used  = (int_eff > ONE) && (int_eff != {BITS{1'b1}});
    acc_sum    = {1'b0, acc} + {1'b0, frac_eff};
    carry      = frac_used & acc_sum[FRAC_BITS];
    base_limit = (int_eff > ONE) ? (int_eff - ONE) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      limit      <= DEF_LIMIT;
      os_cnt     <= '0;
      acc        <= '0;
      div_int_q  <= DEF_INT;
      div_frac_q <= '0;
      pend_int   <= '0;
      pend_frac  <= '0;
      pending    <= 1'b0;
    end else if (restart) begin
      cnt        <= '0;
      os_cnt     <= '0;
      acc        <= '0;
      limit      <= base_limit;
      div_int_q  <= int_eff;
      div_frac_q <= frac_eff;
      pending    <= 1'b0;
    end else begin
      if (wrap) begin
        cnt    <= '0;
        os_cnt <= os_cnt + OS_ONE;
        limit  <= base_limit + BITS'(carry);
        if (frac_used) begin
          acc <= acc_sum[FRAC_BITS-1:0];
        end
      end else if (enable) begin
        cnt <= cnt + ONE;
      end

      // Frozen counters have no period to glitch, so a load lands at once.
      if (wrap || !enable) begin
        div_int_q  <= int_eff;
        div_frac_q <= frac_eff;
        pending    <= 1'b0;
      end else if (div_load) begin
        pend_int  <= div_int;
        pend_frac <= div_frac;
        pending   <= 1'b1;
      end
    end
  end

  assign os_tick      = wrap;
  assign mid_tick     = wrap & (os_cnt == MID_IDX);
  assign bit_tick     = wrap & (os_cnt == BIT_IDX);
  assign load_pending = pending;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: directed scenarios plus random traffic, all
// checked cycle by cycle against a period-length reference model.
module tb_baud_tick_gen;

  localparam int BITS        = 11;
  localparam int FRAC_BITS   = 4;
  localparam int OS_BITS     = 4;
  localparam int DEFAULT_INT = 326;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [BITS-1:0]      div_int;
  logic [FRAC_BITS-1:0] div_frac;
  logic                 div_load;
  logic                 restart;
  logic                 os_tick, mid_tick, bit_tick, load_pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .BITS(BITS), .FRAC_BITS(FRAC_BITS), .OS_BITS(OS_BITS), .DEFAULT_INT(DEFAULT_INT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_int(div_int),
    .div_frac(div_frac), .div_load(div_load), .restart(restart),
    .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
    .load_pending(load_pending)
  );

  // Model: clocks elapsed in the current oversample period, that period's
  // length in clocks, fractional remainder, oversample index, divisors.
  int   m_el, m_plen, m_acc, m_osi, m_qi, m_qf, m_pi, m_pf;
  bit   m_pend;
  logic [3:0] exp_vec;

  task automatic model_reset();
    m_el = 0; m_plen = DEFAULT_INT; m_acc = 0; m_osi = 0;
    m_qi = DEFAULT_INT; m_qf = 0; m_pi = 0; m_pf = 0; m_pend = 0;
  endtask

  function automatic logic [3:0] model_out();
    bit os;
    os = enable && !restart && (m_el == m_plen - 1);
    return {os, os && (m_osi == (1 << (OS_BITS - 1)) - 1),
            os && (m_osi == (1 << OS_BITS) - 1), m_pend};
  endfunction

  task automatic model_step();
    int ei, ef, s;
    logic [3:0] o;
    o = model_out();
    if (div_load) begin ei = int'(div_int); ef = int'(div_frac); end
    else if (m_pend) begin ei = m_pi; ef = m_pf; end
    else begin ei = m_qi; ef = m_qf; end
    if (restart) begin
      m_el = 0; m_osi = 0; m_acc = 0; m_plen = (ei < 1) ? 1 : ei;
      m_qi = ei; m_qf = ef; m_pend = 0;
    end else begin
      if (o[3]) begin
        m_el = 0;
        m_osi = (m_osi + 1) % (1 << OS_BITS);
        if (ei >= 2 && ei <= (1 << BITS) - 2) begin
          s = m_acc + ef;
          m_plen = ei + ((s >= (1 << FRAC_BITS)) ? 1 : 0);
          m_acc = s % (1 << FRAC_BITS);
        end else begin
          m_plen = (ei < 1) ? 1 : ei;
        end
      end else if (enable) begin
        m_el = m_el + 1;
      end
      if (o[3] || !enable) begin
        m_qi = ei; m_qf = ef; m_pend = 0;
      end else if (div_load) begin
        m_pi = int'(div_int); m_pf = int'(div_frac); m_pend = 1;
      end
    end
  endtask

  // Drive inputs just after the falling edge and let outputs settle.
  task automatic apply_in(input logic en, input logic rs, input logic dl,
                          input int di, input int df);
    enable = en; restart = rs; div_load = dl;
    div_int = BITS'(di); div_frac = FRAC_BITS'(df);
    #1;
    exp_vec = model_out();
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1; restart = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
    #12;
    n_cmp++;
    if ({os_tick, mid_tick, bit_tick, load_pending} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_hold got=%b want=0000", {os_tick, mid_tick, bit_tick, load_pending});
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 6; k++) begin
      apply_in(1, 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec || exp_vec !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_release k=%0d got=%b want=%b", k,
                 {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      cycle();
    end
  endtask

  task automatic test_basic();
    int os_n = 0, mid_at = -1, bit_at = -1, bit2_at = -1;
    apply_in(1, 1, 1, 10, 0);
    cycle();
    for (int k = 1; k <= 330; k++) begin
      apply_in(1, 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL basic k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      if (os_tick) os_n++;
      if (mid_tick && mid_at < 0) mid_at = k;
      if (bit_tick) begin
        if (bit_at < 0) bit_at = k;
        else if (bit2_at < 0) bit2_at = k;
      end
      cycle();
    end
    n_cmp++;
    if (os_n !== 33) begin n_bad++; $display("FAIL basic_os_count got=%0d want=33", os_n); end
    n_cmp++;
    if (mid_at !== 80) begin n_bad++; $display("FAIL basic_mid_at got=%0d want=80", mid_at); end
    n_cmp++;
    if (bit_at !== 160 || bit2_at !== 320) begin
      n_bad++; $display("FAIL basic_bit_at got=%0d,%0d want=160,320", bit_at, bit2_at);
    end
  endtask

  task automatic test_frac();
    int t[$];
    apply_in(1, 1, 1, 10, 8);
    cycle();
    for (int k = 1; k <= 350; k++) begin
      apply_in(1, 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL frac k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      if (os_tick) t.push_back(k);
      cycle();
    end
    n_cmp++;
    if (t.size() < 33) begin
      n_bad++; $display("FAIL frac_ticks got=%0d want>=33", t.size());
    end else begin
      if (t[0] !== 10 || t[1] !== 20 || t[2] !== 31 || t[3] !== 41 || t[4] !== 52) begin
        n_bad++;
        $display("FAIL frac_first got=%0d,%0d,%0d,%0d,%0d want=10,20,31,41,52", t[0], t[1], t[2], t[3], t[4]);
      end
      n_cmp++;
      if (t[32] - t[0] !== 336) begin
        n_bad++; $display("FAIL frac_span got=%0d want=336", t[32] - t[0]);
      end
    end
  endtask

  task automatic test_load_mid();
    int pend_n = 0, os1 = -1, os2 = -1, pend_after = 0;
    apply_in(1, 1, 1, 10, 0);
    cycle();
    for (int k = 1; k <= 35; k++) begin
      apply_in(1, 0, (k == 4), 20, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL load_mid k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      if (load_pending) pend_n++;
      if (load_pending && k > 10) pend_after++;
      if (os_tick) begin
        if (os1 < 0) os1 = k;
        else if (os2 < 0) os2 = k;
      end
      cycle();
    end
    n_cmp++;
    if (pend_n !== 6 || pend_after !== 0) begin
      n_bad++; $display("FAIL load_mid_pending got=%0d/%0d want=6/0", pend_n, pend_after);
    end
    n_cmp++;
    if (os1 !== 10 || os2 !== 30) begin
      n_bad++; $display("FAIL load_mid_ticks got=%0d,%0d want=10,30", os1, os2);
    end
  endtask

  task automatic test_restart();
    int os1 = -1, mid1 = -1, bit1 = -1;
    apply_in(1, 1, 1, 10, 0);
    cycle();
    for (int k = 1; k <= 53; k++) begin
      apply_in(1, 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL restart_pre k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      cycle();
    end
    apply_in(1, 1, 0, 0, 0);
    n_cmp++;
    if (os_tick !== 1'b0) begin n_bad++; $display("FAIL restart_cycle_tick got=%b want=0", os_tick); end
    cycle();
    for (int j = 1; j <= 165; j++) begin
      apply_in(1, 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL restart_post j=%0d got=%b want=%b", j, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      if (os_tick && os1 < 0) os1 = j;
      if (mid_tick && mid1 < 0) mid1 = j;
      if (bit_tick && bit1 < 0) bit1 = j;
      cycle();
    end
    n_cmp++;
    if (os1 !== 10 || mid1 !== 80 || bit1 !== 160) begin
      n_bad++; $display("FAIL restart_phase got=%0d,%0d,%0d want=10,80,160", os1, mid1, bit1);
    end
  endtask

  task automatic test_enable();
    int os1 = -1, os_n = 0, frz_n = 0, bit_at = -1, rbit_at = -1, r_n = 0;
    apply_in(1, 1, 1, 10, 0);
    cycle();
    for (int k = 1; k <= 20; k++) begin
      apply_in((k < 5 || k > 11), 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL freeze k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      if (os_tick && os1 < 0) os1 = k;
      cycle();
    end
    n_cmp++;
    if (os1 !== 17) begin n_bad++; $display("FAIL freeze_resume got=%0d want=17", os1); end

    apply_in(1, 1, 1, 1, 5);
    cycle();
    for (int k = 1; k <= 39; k++) begin
      apply_in(!(k > 20 && k <= 27), 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL period_one k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      if (k <= 20 && os_tick) os_n++;
      if (k > 20 && k <= 27 && os_tick) frz_n++;
      if (k > 27 && os_tick) r_n++;
      if (bit_tick && k <= 20 && bit_at < 0) bit_at = k;
      if (bit_tick && k > 27 && rbit_at < 0) rbit_at = k - 27;
      cycle();
    end
    n_cmp++;
    if (os_n !== 20 || frz_n !== 0 || r_n !== 12) begin
      n_bad++; $display("FAIL period_one_counts got=%0d,%0d,%0d want=20,0,12", os_n, frz_n, r_n);
    end
    n_cmp++;
    if (bit_at !== 16 || rbit_at !== 12) begin
      n_bad++; $display("FAIL period_one_bit got=%0d,%0d want=16,12", bit_at, rbit_at);
    end
  endtask

  task automatic test_async_reset();
    int first_os = -1, pend_n = 0;
    apply_in(1, 1, 1, 10, 0);
    cycle();
    for (int k = 1; k <= 9; k++) begin
      apply_in(1, 0, (k == 5), 20, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL async_pre k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      cycle();
    end
    apply_in(1, 0, 0, 0, 0);
    n_cmp++;
    if ({os_tick, load_pending} !== 2'b11) begin
      n_bad++; $display("FAIL async_before got=%b want=11", {os_tick, load_pending});
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({os_tick, mid_tick, bit_tick, load_pending} !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_drop got=%b want=0000", {os_tick, mid_tick, bit_tick, load_pending});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 330; k++) begin
      apply_in(1, 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL async_post k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      if (os_tick && first_os < 0) first_os = k;
      if (load_pending) pend_n++;
      cycle();
    end
    n_cmp++;
    if (first_os !== DEFAULT_INT || pend_n !== 0) begin
      n_bad++; $display("FAIL async_period got=%0d/%0d want=%0d/0", first_os, pend_n, DEFAULT_INT);
    end
  endtask

  task automatic test_limit_edge();
    int t[$];
    apply_in(1, 1, 1, 2047, 15);
    cycle();
    for (int k = 1; k <= 4100; k++) begin
      apply_in(1, 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL limit_max k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      if (os_tick) t.push_back(k);
      cycle();
    end
    n_cmp++;
    if (t.size() !== 2 || t[0] !== 2047 || t[1] !== 4094) begin
      n_bad++; $display("FAIL limit_max_ticks got=%0d ticks want=2 at 2047,4094", t.size());
    end
    t.delete();
    apply_in(1, 1, 1, 2046, 8);
    cycle();
    for (int k = 1; k <= 6145; k++) begin
      apply_in(1, 0, 0, 0, 0);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL limit_near k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      if (os_tick) t.push_back(k);
      cycle();
    end
    n_cmp++;
    if (t.size() !== 3 || t[0] !== 2046 || t[1] !== 4092 || t[2] !== 6139) begin
      n_bad++; $display("FAIL limit_near_ticks got=%0d ticks want=3 at 2046,4092,6139", t.size());
    end
  endtask

  task automatic test_random();
    logic en, rs, dl;
    int di, df;
    for (int k = 1; k <= 3000; k++) begin
      en = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 199) == 0);
      dl = ($urandom_range(0, 19) == 0);
      di = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 14));
      df = int'($urandom_range(0, 15));
      apply_in(en, rs, dl, di, df);
      n_cmp++;
      if ({os_tick, mid_tick, bit_tick, load_pending} !== exp_vec) begin
        n_bad++;
        $display("FAIL random k=%0d got=%b want=%b", k, {os_tick, mid_tick, bit_tick, load_pending}, exp_vec);
      end
      cycle();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_load_mid();
    test_restart();
    test_enable();
    test_async_reset();
    test_limit_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
